// File: rtl/fmau_sequencer_if.sv
// Host and FMAU signal bundle for the FMAU sequencer.
// slave: the sequencer side. master: the environment side (host plus FMAU).
interface fmau_sequencer_if;
    // Request channel (host -> sequencer)
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] req_c;
    logic [31:0] req_d;
    logic [1:0]  req_in_pre;
    logic [1:0]  req_out_pre;
    // FMAU side
    logic        fmau_start;
    logic [31:0] fmau_a;
    logic [31:0] fmau_b;
    logic [31:0] fmau_c;
    logic [31:0] fmau_d;
    logic [1:0]  fmau_in_pre;
    logic [1:0]  fmau_out_pre;
    logic [31:0] fmau_out;
    logic        fmau_soe;
    // Response channel (sequencer -> host)
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_d, req_in_pre, req_out_pre,
        input  fmau_out, fmau_soe, rsp_ready,
        output req_ready, fmau_start, fmau_a, fmau_b, fmau_c, fmau_d,
        output fmau_in_pre, fmau_out_pre, rsp_valid, rsp_data, rsp_timeout, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_c, req_d, req_in_pre, req_out_pre,
        output fmau_out, fmau_soe, rsp_ready,
        input  req_ready, fmau_start, fmau_a, fmau_b, fmau_c, fmau_d,
        input  fmau_in_pre, fmau_out_pre, rsp_valid, rsp_data, rsp_timeout, busy
    );
endinterface

// File: rtl/fmau_sequencer.sv
// FMAU sequencer: accepts one operand set at a time, issues it to the FMAU
// with a one-cycle start pulse, waits for the result (or a timeout) and queues
// {timeout, result} entries in a small result FIFO for the host.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// may be held without a transfer, ready never depends on valid in this block.
module fmau_sequencer #(
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    fmau_sequencer_if.slave   bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [1:0]  in_pre;
        logic [1:0]  out_pre;
    } op_t;

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] NAR = 32'h8000_0000;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           start_q, start_d;
    op_t            op_q, op_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    mem_data_q [RES_DEPTH];
    logic [31:0]    mem_data_d [RES_DEPTH];
    logic           mem_tout_q [RES_DEPTH];
    logic           mem_tout_d [RES_DEPTH];

    logic           req_ready;
    logic           accept;
    logic           push;
    logic           pop;
    logic [31:0]    push_data;
    logic           push_tout;

    // Acceptance only in IDLE with FIFO room, so a push can never hit a full FIFO.
    assign req_ready = (state_q == S_IDLE) && (count_q < CW'(RES_DEPTH));
    assign accept    = bus.req_valid && req_ready;
    assign pop       = (count_q != '0) && bus.rsp_ready;

    // Next-state logic: operand capture, start pulse, WAIT timer and result push.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        start_d   = 1'b0;
        op_d      = op_q;
        push      = 1'b0;
        push_data = bus.fmau_out;
        push_tout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    start_d = 1'b1;
                    op_d    = '{a: bus.req_a, b: bus.req_b, c: bus.req_c, d: bus.req_d,
                                in_pre: bus.req_in_pre, out_pre: bus.req_out_pre};
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A result arriving on the last allowed cycle beats the timeout.
                if (bus.fmau_soe) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    push      = 1'b1;
                    push_tout = 1'b1;
                    push_data = NAR;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping: write at wr_ptr, read at rd_ptr, count tracks occupancy.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_tout_d = mem_tout_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = push_data;
            mem_tout_d[wr_ptr_q] = push_tout;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer state and FMAU-facing registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            start_q <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            start_q <= start_d;
            op_q    <= op_d;
        end
    end

    // Result FIFO storage and pointers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_data_q <= '{default: '0};
            mem_tout_q <= '{default: 1'b0};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_data_q <= mem_data_d;
            mem_tout_q <= mem_tout_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.fmau_start   = start_q;
    assign bus.fmau_a       = op_q.a;
    assign bus.fmau_b       = op_q.b;
    assign bus.fmau_c       = op_q.c;
    assign bus.fmau_d       = op_q.d;
    assign bus.fmau_in_pre  = op_q.in_pre;
    assign bus.fmau_out_pre = op_q.out_pre;
    assign bus.rsp_valid    = (count_q != '0);
    assign bus.rsp_data     = mem_data_q[rd_ptr_q];
    assign bus.rsp_timeout  = mem_tout_q[rd_ptr_q];
    assign bus.busy         = (state_q != S_IDLE);
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_fmau_sequencer.sv
// Testbench for fmau_sequencer. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_fmau_sequencer;
    localparam int RES_DEPTH = 4;
    localparam int TIMEOUT   = 8;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    fmau_sequencer_if bus();

    fmau_sequencer #(.RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];   // scoreboard: {timeout, data} in expected pop order

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0;
        bus.req_in_pre = '0; bus.req_out_pre = '0;
        bus.fmau_out = '0; bus.fmau_soe = 1'b0; bus.rsp_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Offer one request; returns in the cycle after acceptance (the ISSUE cycle).
    task automatic send_req(input logic [31:0] a, b, c, d, input logic [1:0] ip, op,
                            output bit ok);
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_c = c; bus.req_d = d;
        bus.req_in_pre = ip; bus.req_out_pre = op;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
            step();
        end
        bus.req_valid = 1'b0;
    endtask

    // From the ISSUE cycle: run WAIT cycles, pulsing soe with res in WAIT cycle d.
    task automatic run_op(input int d, input logic [31:0] res);
        step();
        for (int k = 0; k <= TIMEOUT + 1; k++) begin
            if (k == d) begin bus.fmau_soe = 1'b1; bus.fmau_out = res; end
            step();
            bus.fmau_soe = 1'b0;
        end
    endtask

    // Pop the head, returning what was presented just before the pop edge.
    task automatic pop_one(output logic v, output logic [32:0] got);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        v   = bus.rsp_valid;
        got = {bus.rsp_timeout, bus.rsp_data};
        step();
        bus.rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) step();
        checks++; if ({bus.fmau_start, bus.fmau_a, bus.fmau_b, bus.fmau_c, bus.fmau_d} !== '0) begin
            errors++; $display("FAIL reset_fmau: got %h expected 0", {bus.fmau_a, bus.fmau_b, bus.fmau_c, bus.fmau_d}); end
        checks++; if ({bus.fmau_in_pre, bus.fmau_out_pre, bus.rsp_valid, bus.rsp_timeout, bus.busy} !== '0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0", {bus.fmau_in_pre, bus.fmau_out_pre, bus.rsp_valid, bus.rsp_timeout, bus.busy}); end
        checks++; if (bus.rsp_data !== 32'h0) begin
            errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
        rst = 1'b0;
        step();
        checks++; if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        exp_q.delete();
    endtask

    task automatic test_single_op();
        bit ok;
        logic v; logic [32:0] got;
        send_req(32'hEC5A5A5A, 32'h5A5A5A5A, 32'h6D5B5ADA, 32'h5A525A7A, 2'b00, 2'b00, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept: got 0 expected 1"); end
        @(negedge clk);
        checks++; if (bus.fmau_start !== 1'b1) begin
            errors++; $display("FAIL single_start: got %b expected 1", bus.fmau_start); end
        checks++; if ({bus.fmau_a, bus.fmau_b, bus.fmau_c, bus.fmau_d} !== {32'hEC5A5A5A, 32'h5A5A5A5A, 32'h6D5B5ADA, 32'h5A525A7A}) begin
            errors++; $display("FAIL single_operands: got %h expected ec5a5a5a5a5a5a5a6d5b5ada5a525a7a", {bus.fmau_a, bus.fmau_b, bus.fmau_c, bus.fmau_d}); end
        step();
        @(negedge clk);
        checks++; if (bus.fmau_start !== 1'b0) begin
            errors++; $display("FAIL single_start_pulse: got %b expected 0", bus.fmau_start); end
        step();
        step();
        bus.fmau_soe = 1'b1; bus.fmau_out = 32'h1234_5678;
        step();
        bus.fmau_soe = 1'b0;
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_data, bus.busy} !== {1'b1, 1'b0, 32'h12345678, 1'b0}) begin
            errors++; $display("FAIL single_rsp: got v=%b t=%b d=%h busy=%b expected v=1 t=0 d=12345678 busy=0",
                               bus.rsp_valid, bus.rsp_timeout, bus.rsp_data, bus.busy); end
        checks++; if (bus.fmau_a !== 32'hEC5A5A5A) begin
            errors++; $display("FAIL single_hold: got %h expected ec5a5a5a", bus.fmau_a); end
        step();
        pop_one(v, got);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop_empty: got %b expected 0", bus.rsp_valid); end
        step();
    endtask

    task automatic test_timeout();
        bit ok;
        int busy_cycles;
        logic v; logic [32:0] got;
        send_req($urandom, $urandom, $urandom, $urandom, 2'b01, 2'b10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_accept: got 0 expected 1"); end
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            busy_cycles++;
            step();
        end
        // one ISSUE cycle plus TIMEOUT WAIT cycles
        checks++; if (busy_cycles != TIMEOUT + 1) begin
            errors++; $display("FAIL timeout_busy_cycles: got %0d expected %0d", busy_cycles, TIMEOUT + 1); end
        checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_data} !== {1'b1, 1'b1, NAR}) begin
            errors++; $display("FAIL timeout_entry: got v=%b t=%b d=%h expected v=1 t=1 d=80000000",
                               bus.rsp_valid, bus.rsp_timeout, bus.rsp_data); end
        step();
        pop_one(v, got);
        checks++; if ({v, got} !== {1'b1, 1'b1, NAR}) begin
            errors++; $display("FAIL timeout_pop: got %h expected %h", {v, got}, {1'b1, 1'b1, NAR}); end
    endtask

    task automatic test_race();
        bit ok;
        logic [31:0] res;
        logic v; logic [32:0] got;
        res = $urandom;
        send_req($urandom, $urandom, $urandom, $urandom, 2'b11, 2'b00, ok);
        checks++; if (!ok) begin errors++; $display("FAIL race_accept: got 0 expected 1"); end
        run_op(TIMEOUT - 1, res);
        pop_one(v, got);
        checks++; if ({v, got} !== {1'b1, 1'b0, res}) begin
            errors++; $display("FAIL race_entry: got %h expected %h", {v, got}, {1'b1, 1'b0, res}); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL race_single_push: got %b expected 0", bus.rsp_valid); end
        step();
    endtask

    task automatic test_full_fifo();
        bit ok;
        logic [31:0] val;
        logic [31:0] fifth_a;
        logic v; logic [32:0] got;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < RES_DEPTH; i++) begin
            val = $urandom;
            send_req($urandom, $urandom, $urandom, $urandom, 2'b00, 2'b01, ok);
            run_op(1, val);
            exp_q.push_back({1'b0, val});
        end
        fifth_a = $urandom;
        bus.req_valid = 1'b1; bus.req_a = fifth_a;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 1'b0) begin
                errors++; $display("FAIL full_req_ready_low: got %b expected 0", bus.req_ready); end
            step();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.rsp_timeout, bus.rsp_data} !== exp_q[0]) begin
            errors++; $display("FAIL full_head: got %h expected %h", {bus.rsp_timeout, bus.rsp_data}, exp_q[0]); end
        step();
        bus.rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL full_req_ready_after_pop: got %b expected 1", bus.req_ready); end
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.fmau_start, bus.fmau_a} !== {1'b1, fifth_a}) begin
            errors++; $display("FAIL full_fifth_issue: got %h expected %h", {bus.fmau_start, bus.fmau_a}, {1'b1, fifth_a}); end
        val = $urandom;
        run_op(0, val);
        exp_q.push_back({1'b0, val});
        while (exp_q.size() != 0) begin
            pop_one(v, got);
            checks++; if ({v, got} !== {1'b1, exp_q[0]}) begin
                errors++; $display("FAIL full_drain: got %h expected %h", {v, got}, {1'b1, exp_q[0]}); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        logic [31:0] val;
        logic v; logic [32:0] got;
        // leave a stale entry so the reset has storage to clear
        send_req(32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3, 2'b10, 2'b11, ok);
        run_op(0, 32'hDEAD_BEEF);
        send_req(32'hA5A5_A5A5, 32'h1, 32'h2, 32'h3, 2'b10, 2'b11, ok);
        step(); step();
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.fmau_start, bus.fmau_a, bus.fmau_b, bus.fmau_c, bus.fmau_d, bus.fmau_in_pre, bus.fmau_out_pre} !== '0) begin
            errors++; $display("FAIL midwait_fmau_zero: got a=%h pre=%b%b", bus.fmau_a, bus.fmau_in_pre, bus.fmau_out_pre); end
        checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_data, bus.busy} !== '0) begin
            errors++; $display("FAIL midwait_rsp_zero: got v=%b t=%b d=%h busy=%b expected 0",
                               bus.rsp_valid, bus.rsp_timeout, bus.rsp_data, bus.busy); end
        step();
        rst = 1'b0;
        exp_q.delete();
        bus.fmau_soe = 1'b1; bus.fmau_out = 32'hCAFE_F00D;
        step();
        bus.fmau_soe = 1'b0;
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.busy, bus.fmau_start} !== 3'b000) begin
            errors++; $display("FAIL midwait_late_soe: got %b expected 000", {bus.rsp_valid, bus.busy, bus.fmau_start}); end
        step();
        val = $urandom;
        send_req(32'h0BAD_CAFE, $urandom, $urandom, $urandom, 2'b01, 2'b01, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midwait_next_accept: got 0 expected 1"); end
        run_op(3, val);
        pop_one(v, got);
        checks++; if ({v, got} !== {1'b1, 1'b0, val}) begin
            errors++; $display("FAIL midwait_next_result: got %h expected %h", {v, got}, {1'b1, 1'b0, val}); end
    endtask

    task automatic test_stray_soe();
        bit ok;
        logic [31:0] val;
        logic v; logic [32:0] got;
        for (int i = 0; i < 3; i++) begin
            bus.fmau_soe = 1'b1; bus.fmau_out = $urandom;
            step();
            bus.fmau_soe = 1'b0;
            @(negedge clk);
            checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                errors++; $display("FAIL stray_soe: got %b expected 00", {bus.rsp_valid, bus.busy}); end
            step();
        end
        // popping an empty FIFO must not disturb its count
        bus.rsp_ready = 1'b1;
        step(); step();
        bus.rsp_ready = 1'b0;
        val = $urandom;
        send_req($urandom, $urandom, $urandom, $urandom, 2'b00, 2'b00, ok);
        run_op(2, val);
        pop_one(v, got);
        checks++; if ({v, got} !== {1'b1, 1'b0, val}) begin
            errors++; $display("FAIL stray_then_op: got %h expected %h", {v, got}, {1'b1, 1'b0, val}); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL empty_pop_count: got %b expected 0", bus.rsp_valid); end
        step();
    endtask

    // Random ops: soe arrives after d WAIT cycles (d may exceed the timeout window).
    task automatic test_random();
        bit ok;
        int d;
        int last_wait;
        logic [31:0] res, b;
        logic v; logic [32:0] got;
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == RES_DEPTH || (exp_q.size() != 0 && $urandom_range(0, 1) == 1)) begin
                pop_one(v, got);
                checks++; if ({v, got} !== {1'b1, exp_q[0]}) begin
                    errors++; $display("FAIL random_pop: got %h expected %h", {v, got}, {1'b1, exp_q[0]}); end
                void'(exp_q.pop_front());
            end
            d   = $urandom_range(0, TIMEOUT + 2);
            res = $urandom;
            b   = $urandom;
            send_req($urandom, b, $urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ok);
            checks++; if (!ok) begin errors++; $display("FAIL random_accept: got 0 expected 1"); end
            @(negedge clk);
            checks++; if ({bus.fmau_start, bus.fmau_b} !== {1'b1, b}) begin
                errors++; $display("FAIL random_issue: got %h expected %h", {bus.fmau_start, bus.fmau_b}, {1'b1, b}); end
            // the last WAIT cycle is the soe cycle or the final timeout cycle
            last_wait = (d < TIMEOUT) ? d : TIMEOUT - 1;
            step();
            for (int k = 0; k <= TIMEOUT + 1; k++) begin
                if (k == d) begin bus.fmau_soe = 1'b1; bus.fmau_out = res; end
                @(negedge clk);
                checks++; if (bus.busy !== (k <= last_wait)) begin
                    errors++; $display("FAIL random_busy k=%0d d=%0d: got %b expected %b", k, d, bus.busy, (k <= last_wait)); end
                step();
                bus.fmau_soe = 1'b0;
            end
            exp_q.push_back((d < TIMEOUT) ? {1'b0, res} : {1'b1, NAR});
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1) begin
                errors++; $display("FAIL random_rsp_valid: got %b expected 1", bus.rsp_valid); end
            step();
        end
        while (exp_q.size() != 0) begin
            pop_one(v, got);
            checks++; if ({v, got} !== {1'b1, exp_q[0]}) begin
                errors++; $display("FAIL random_drain: got %h expected %h", {v, got}, {1'b1, exp_q[0]}); end
            void'(exp_q.pop_front());
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_op();
        test_timeout();
        test_race();
        test_full_fifo();
        test_reset_mid_wait();
        test_stray_soe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmau_sequencer.md
FMAU_SEQUENCER -- requirements
Module: fmau_sequencer

Interface
REQ-001 Parameter RES_DEPTH, default 4: result FIFO depth in entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 255: maximum number of WAIT cycles before the unit is declared hung, 1..1023.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous assertion, active-high.
REQ-005 req_valid  in  1  host offers one operand set.
REQ-006 req_ready  out  1  sequencer accepts the operand set this cycle.
REQ-007 req_a, req_b, req_c, req_d  in  32 each  operands.
REQ-008 req_in_pre, req_out_pre  in  2 each  input and output precision codes.
REQ-009 fmau_start  out  1  start pulse to the FMAU.
REQ-010 fmau_a, fmau_b, fmau_c, fmau_d  out  32 each  operands to the FMAU.
REQ-011 fmau_in_pre, fmau_out_pre  out  2 each  precision codes to the FMAU.
REQ-012 fmau_out  in  32  FMAU result.
REQ-013 fmau_soe  in  1  FMAU result valid, one-cycle pulse.
REQ-014 rsp_valid  out  1  FIFO head is valid.
REQ-015 rsp_ready  in  1  host pops the head.
REQ-016 rsp_data  out  32  head result.
REQ-017 rsp_timeout  out  1  head entry was produced by a timeout.
REQ-018 busy  out  1  state is not IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT; at most one operation outstanding.
REQ-020 req_ready SHALL be 1 only when state is IDLE and FIFO count < RES_DEPTH; its value is combinational from registered state.
REQ-021 On req_valid && req_ready, all operand and precision inputs SHALL be registered onto the fmau_* operand and precision outputs, and the FSM moves IDLE -> ISSUE.
REQ-022 fmau_* operand and precision outputs SHALL hold their values until the next acceptance.
REQ-023 ISSUE: fmau_start SHALL be a registered output, high for exactly one cycle (the ISSUE cycle); timer cleared; next state WAIT.
REQ-024 WAIT: timer increments each cycle; on fmau_soe, push {timeout=0, fmau_out} into the FIFO and move to IDLE.
REQ-025 WAIT with timer == TIMEOUT-1 and no fmau_soe: push {timeout=1, 32'h8000_0000 (NaR)} and move to IDLE.
REQ-026 If fmau_soe and the timeout condition occur in the same cycle, fmau_soe SHALL win.
REQ-027 fmau_soe outside WAIT SHALL be ignored, with no push.
REQ-028 FIFO: rsp_valid = (count != 0); rsp_data and rsp_timeout present the head; pop on rsp_valid && rsp_ready.
REQ-029 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo RES_DEPTH.
REQ-030 Because acceptance requires count < RES_DEPTH, a push SHALL never occur while the FIFO is full.
REQ-031 Latency: acceptance at edge N -> fmau_start high in cycle N+1. fmau_soe sampled at edge M -> rsp_valid high after edge M (when the FIFO was empty). IDLE resumes after edge M, so the next acceptance can occur at edge M+1.
REQ-032 rsp_ready asserted while the FIFO is empty SHALL have no effect.

Reset
REQ-033 rst SHALL force, asynchronously: state IDLE; timer 0; FIFO empty; fmau_start 0; all fmau_* outputs 0; rsp_valid 0; rsp_data 0; rsp_timeout 0; busy 0.
REQ-034 Reset during WAIT abandons the operation; a late fmau_soe after reset release SHALL be ignored (per REQ-027).

Verification
REQ-035 Single op: req A=32'hEC5A5A5A, B=32'h5A5A5A5A, C=32'h6D5B5ADA, D=32'h5A525A7A, pre=2'b00/2'b00 -> fmau_start is one 1-cycle pulse carrying these operands. fmau_soe with fmau_out=32'h1234_5678 three cycles later -> rsp_valid=1, rsp_data=32'h12345678, rsp_timeout=0.
REQ-036 Timeout: TIMEOUT=8, soe never asserted -> exactly 8 WAIT cycles, then an entry 32'h80000000 with rsp_timeout=1, and busy drops.
REQ-037 Full FIFO: rsp_ready=0, four ops completed -> req_ready=0 with req_valid held. One pop -> req_ready=1 the next cycle and the fifth op is accepted.
REQ-038 Race: fmau_soe in the same cycle the timeout condition is met -> entry holds fmau_out with rsp_timeout=0; exactly one push.
REQ-039 Reset mid-WAIT: rst pulse, then fmau_soe -> FIFO stays empty, all outputs 0, next request accepted normally.
REQ-040 Stray soe: fmau_soe pulsed while in IDLE -> no FIFO push; rsp_valid stays 0.
